// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between I-cache and D-cache line bursts.
// Round-robin grant, one owner per whole line, per-beat addressing and read return.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache port (read only)
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  // D-cache port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  // Memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned BeatW = $clog2(LINE_WORDS);
  localparam int unsigned OffW  = BeatW + 2;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);
  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e                 r_state, w_state_next;
  logic [ADDR_W-OffW-1:0] r_base, w_base_next;
  logic [BeatW-1:0]       r_beat, w_beat_next;
  logic                   r_owner, w_owner_next;
  logic                   r_we, w_we_next;
  logic                   r_last, w_last_next;

  logic [DATA_W-1:0]      r_i_rdata, r_d_rdata;
  logic                   r_i_rvalid, r_d_rvalid;

  logic                   w_grant_d;
  logic                   w_xfer;
  logic                   w_rd_ack;
  logic                   w_unused;

  // Line offset bits of the request addresses are intentionally ignored.
  assign w_unused = ^{i_addr[OffW-1:0], d_addr[OffW-1:0]};

  // D wins if it is alone, or on a tie when I was served last.
  assign w_grant_d = d_req && (!i_req || (r_last == OwnI));
  assign w_xfer    = (r_state == StXfer);
  assign w_rd_ack  = w_xfer && mem_ack && !r_we;

  always_comb begin
    w_state_next = r_state;
    w_base_next  = r_base;
    w_beat_next  = r_beat;
    w_owner_next = r_owner;
    w_we_next    = r_we;
    w_last_next  = r_last;
    unique case (r_state)
      StIdle: begin
        if (i_req || d_req) begin
          w_state_next = StXfer;
          w_owner_next = w_grant_d ? OwnD : OwnI;
          w_base_next  = w_grant_d ? d_addr[ADDR_W-1:OffW] : i_addr[ADDR_W-1:OffW];
          w_we_next    = w_grant_d && d_we;
          w_beat_next  = '0;
        end
      end
      StXfer: begin
        if (mem_ack) begin
          w_beat_next = r_beat + 1'b1;
          if (r_beat == LastBeat) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_last_next  = r_owner;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_beat  <= '0;
      r_owner <= OwnI;
      r_we    <= 1'b0;
      r_last  <= OwnI;
    end else begin
      r_state <= w_state_next;
      r_base  <= w_base_next;
      r_beat  <= w_beat_next;
      r_owner <= w_owner_next;
      r_we    <= w_we_next;
      r_last  <= w_last_next;
    end
  end

  // Read return: captured on the ack edge, presented to the owner one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_i_rvalid <= w_rd_ack && (r_owner == OwnI);
      r_d_rvalid <= w_rd_ack && (r_owner == OwnD);
      if (w_rd_ack && (r_owner == OwnI)) begin
        r_i_rdata <= mem_rdata;
      end
      if (w_rd_ack && (r_owner == OwnD)) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = w_xfer;
  assign mem_we    = w_xfer && r_we;
  assign mem_addr  = w_xfer ? {r_base, r_beat, 2'b00} : '0;
  assign mem_wdata = d_wdata;

  assign d_wready  = w_xfer && mem_ack && (r_owner == OwnD) && r_we;

  assign i_rdata   = r_i_rdata;
  assign i_rvalid  = r_i_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_rvalid  = r_d_rvalid;

  assign i_done    = (r_state == StDone) && (r_owner == OwnI);
  assign d_done    = (r_state == StDone) && (r_owner == OwnD);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with wait states,
// read-data and write-data scoreboards, one task per scenario.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_rvalid, d_rvalid, i_done, d_done, d_wready;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   wait_states = 0;
  int unsigned   wcnt = 0;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory model: acks after wait_states idle cycles; reads push the expected word.
  task automatic mem_step();
    if (mem_req && wcnt >= wait_states) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr ^ 32'hDEAD_BEEF;
      wcnt      = 0;
      if (!mem_we) rd_q.push_back(mem_addr ^ 32'hDEAD_BEEF);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      wcnt      = mem_req ? wcnt + 1 : 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    wcnt = 0;
  endtask

  task automatic test_reset();
    bit fin = 0;
    int nr = 0;
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h1000_0000; d_addr = 32'h2000_0040; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      mem_step();
    end
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, i_rvalid, d_rvalid, i_done, d_done, i_rdata, d_rdata,
         d_wready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_req=%b mem_addr=%h i_rvalid=%b d_rvalid=%b i_done=%b d_done=%b i_rdata=%h d_rdata=%h, want all 0",
               mem_req, mem_addr, i_rvalid, d_rvalid, i_done, d_done, i_rdata, d_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_step();
    @(negedge clk);
    mem_step();
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000_0040) begin
      n_fail++;
      $display("FAIL reset_first_grant: mem_req=%b mem_addr=%h, want 1 / 20000040", mem_req, mem_addr);
    end
    for (int c = 0; c < 20 && !fin; c++) begin
      if (c > 0) begin
        @(negedge clk);
        mem_step();
        #1;
      end
      if (i_rvalid) begin
        n_checks++; n_fail++;
        $display("FAIL reset_i_rvalid: got 1, want 0 during D burst");
      end
      if (d_rvalid) begin
        logic [DW-1:0] e;
        e = rd_q.pop_front();
        nr++;
        n_checks++;
        if (d_rdata !== e) begin
          n_fail++;
          $display("FAIL reset_d_rdata: got %h want %h", d_rdata, e);
        end
      end
      if (d_done) begin
        n_checks++;
        if (nr != LW) begin
          n_fail++;
          $display("FAIL reset_d_beats: got %0d want %0d", nr, LW);
        end
        i_req = 1'b0; d_req = 1'b0;
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL reset_timeout: d_done got 0 want 1");
    end
    idle(2);
  endtask

  task automatic test_i_read();
    bit fin = 0;
    int na = 0, nr = 0, first = -1;
    wait_states = 0;
    @(negedge clk);
    i_addr = 32'h1234_5678; i_req = 1'b1;
    mem_step();
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      mem_step();
      #1;
      if (mem_req && first < 0) first = c;
      if (mem_ack) begin
        n_checks++;
        if (mem_addr !== 32'h1234_5670 + 32'(4 * na)) begin
          n_fail++;
          $display("FAIL iread_addr%0d: got %h want %h", na, mem_addr, 32'h1234_5670 + 32'(4 * na));
        end
        na++;
      end
      if (d_rvalid) begin
        n_checks++; n_fail++;
        $display("FAIL iread_d_rvalid: got 1 want 0");
      end
      if (i_rvalid) begin
        logic [DW-1:0] e;
        e = rd_q.pop_front();
        nr++;
        n_checks++;
        if (i_rdata !== e) begin
          n_fail++;
          $display("FAIL iread_rdata%0d: got %h want %h", nr, i_rdata, e);
        end
      end
      if (i_done) begin
        n_checks++;
        if (nr != 4 || i_rvalid !== 1'b1 || c - first != 4) begin
          n_fail++;
          $display("FAIL iread_done: beats=%0d rvalid=%b cycles=%0d, want 4 / 1 / 4",
                   nr, i_rvalid, c - first);
        end
        i_req = 1'b0;
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL iread_timeout: i_done got 0 want 1");
    end
    idle(2);
  endtask

  task automatic test_d_write();
    bit fin = 0;
    int wi = 0, na = 0;
    wait_states = 2;
    for (int k = 0; k < 4; k++) wr_q.push_back(32'hA0 + 32'(k));
    @(negedge clk);
    d_addr = 32'h0000_8000; d_we = 1'b1; d_req = 1'b1; d_wdata = 32'hA0;
    mem_step();
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      d_wdata = 32'hA0 + 32'(wi);
      mem_step();
      #1;
      if (mem_req) begin
        n_checks++;
        if (d_wready !== mem_ack || mem_we !== 1'b1) begin
          n_fail++;
          $display("FAIL dwr_align: wready=%b ack=%b we=%b, want wready=ack and we=1",
                   d_wready, mem_ack, mem_we);
        end
      end
      if (mem_ack) begin
        n_checks++;
        if (mem_addr !== 32'h0000_8000 + 32'(4 * na)) begin
          n_fail++;
          $display("FAIL dwr_addr%0d: got %h want %h", na, mem_addr, 32'h0000_8000 + 32'(4 * na));
        end
        na++;
      end
      if (d_wready) begin
        logic [DW-1:0] e;
        e = wr_q.pop_front();
        n_checks++;
        if (mem_wdata !== e) begin
          n_fail++;
          $display("FAIL dwr_wdata%0d: got %h want %h", wi, mem_wdata, e);
        end
        wi++;
      end
      if (i_rvalid || d_rvalid) begin
        n_checks++; n_fail++;
        $display("FAIL dwr_rvalid: got 1 want 0 during write");
      end
      if (d_done) begin
        n_checks++;
        if (wi != 4) begin
          n_fail++;
          $display("FAIL dwr_beats: got %0d want 4", wi);
        end
        d_req = 1'b0;
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL dwr_timeout: d_done got 0 want 1");
    end
    d_we = 1'b0;
    wr_q.delete();
    idle(2);
  endtask

  task automatic test_both_held();
    bit fin = 0, prev = 0, exp_d = 0, is_d;
    int gi = 0, nd = 0;
    wait_states = 0;
    do_reset();
    i_addr = 32'h0000_3000; d_addr = 32'h0000_5000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk);
      mem_step();
      #1;
      if (mem_req && !prev) begin
        gi++;
        exp_d = (gi % 2) == 1;
        is_d  = (mem_addr == 32'h0000_5000);
        n_checks++;
        if (is_d !== exp_d) begin
          n_fail++;
          $display("FAIL both_grant%0d: got %s want %s", gi, is_d ? "D" : "I", exp_d ? "D" : "I");
        end
      end
      prev = mem_req;
      if (i_rvalid || d_rvalid) begin
        logic [DW-1:0] e;
        e = rd_q.pop_front();
        n_checks++;
        if ({i_rvalid, d_rvalid} !== (exp_d ? 2'b01 : 2'b10) ||
            (exp_d ? d_rdata : i_rdata) !== e) begin
          n_fail++;
          $display("FAIL both_rvalid: i/d rvalid=%b%b data=%h, want owner %s data %h",
                   i_rvalid, d_rvalid, exp_d ? d_rdata : i_rdata, exp_d ? "D" : "I", e);
        end
      end
      if (i_done || d_done) begin
        nd++;
        n_checks++;
        if ({i_done, d_done} !== (exp_d ? 2'b01 : 2'b10) || nd != gi) begin
          n_fail++;
          $display("FAIL both_done%0d: i/d done=%b%b grants=%0d, want owner %s grants %0d",
                   nd, i_done, d_done, gi, exp_d ? "D" : "I", nd);
        end
        if (nd == 4) begin
          i_req = 1'b0; d_req = 1'b0;
          fin = 1;
        end
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL both_timeout: dones got %0d want 4", nd);
    end
    idle(2);
  endtask

  task automatic test_mid_burst();
    bit fin = 0;
    int na = 0, nr = 0;
    wait_states = 1;
    @(negedge clk);
    i_addr = 32'h0000_4000; i_req = 1'b1;
    mem_step();
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      mem_step();
      #1;
      if (mem_ack) begin
        n_checks++;
        if (mem_addr !== 32'h0000_4000 + 32'(4 * na)) begin
          n_fail++;
          $display("FAIL mid_addr%0d: got %h want %h", na, mem_addr, 32'h0000_4000 + 32'(4 * na));
        end
        na++;
        if (na == 2) begin
          i_req = 1'b0; i_addr = 32'h0000_9990;
        end
      end
      if (i_rvalid) begin
        logic [DW-1:0] e;
        e = rd_q.pop_front();
        nr++;
        n_checks++;
        if (i_rdata !== e) begin
          n_fail++;
          $display("FAIL mid_rdata%0d: got %h want %h", nr, i_rdata, e);
        end
      end
      if (i_done) begin
        n_checks++;
        if (na != 4 || nr != 4) begin
          n_fail++;
          $display("FAIL mid_beats: acks=%0d rvalids=%0d want 4/4", na, nr);
        end
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL mid_timeout: i_done got 0 want 1");
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    bit fin = 0, hit = 0;
    int na = 0, nr = 0;
    wait_states = 0;
    @(negedge clk);
    d_addr = 32'h0000_2000; d_we = 1'b0; d_req = 1'b1;
    mem_step();
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      mem_step();
      #1;
      if (d_rvalid) void'(rd_q.pop_front());
      if (mem_ack) na++;
      if (na == 3) begin
        rst = 1'b1;
        hit = 1;
      end
    end
    @(negedge clk);
    mem_step();
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || d_done !== 1'b0 || d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_abort: mem_req=%b d_done=%b d_rvalid=%b, want 0/0/0",
               mem_req, d_done, d_rvalid);
    end
    rst = 1'b0;
    rd_q.delete();
    na = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      mem_step();
      #1;
      if (mem_ack) begin
        n_checks++;
        if (mem_addr !== 32'h0000_2000 + 32'(4 * na)) begin
          n_fail++;
          $display("FAIL rstmid_addr%0d: got %h want %h", na, mem_addr, 32'h0000_2000 + 32'(4 * na));
        end
        na++;
      end
      if (d_rvalid) begin
        logic [DW-1:0] e;
        e = rd_q.pop_front();
        nr++;
        n_checks++;
        if (d_rdata !== e) begin
          n_fail++;
          $display("FAIL rstmid_rdata%0d: got %h want %h", nr, d_rdata, e);
        end
      end
      if (d_done) begin
        n_checks++;
        if (na != 4 || nr != 4) begin
          n_fail++;
          $display("FAIL rstmid_beats: acks=%0d rvalids=%0d want 4/4", na, nr);
        end
        d_req = 1'b0;
        fin = 1;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL rstmid_timeout: d_done got 0 want 1");
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_both_held();
    test_mid_burst();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
